// File: rtl/cmprs_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Compressor input between NUM_PORTS AXI-stream sources.
// Define CMPRS_ARB_TIMEOUT_EN to force-terminate packets whose source stalls for TIMEOUT_CYCLES.
module cmprs_pkt_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned KEEP_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
  input  logic [NUM_PORTS-1:0]             s_tvalid,
  input  logic [NUM_PORTS-1:0]             s_tlast,
  output logic [NUM_PORTS-1:0]             s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [KEEP_WIDTH-1:0]            m_tkeep,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int unsigned GW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("cmprs_pkt_arbiter: unsupported NUM_PORTS/TIMEOUT_CYCLES");
  end

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   pick, cand;
  logic            pick_vld;
  logic            term;

  // first requester strictly after rr_q, wrapping modulo NUM_PORTS
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = GW'((32'(rr_q) + i) % NUM_PORTS);
      if (!pick_vld && s_tvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef CMPRS_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // once the limit is hit the counter freezes so the terminating beat holds until accepted
  always_comb begin
    term    = (state_q == LOCKED) && (stall_q == CW'(TIMEOUT_CYCLES));
    stall_d = stall_q;
    if (state_q != LOCKED)       stall_d = '0;
    else if (term)               stall_d = stall_q;
    else if (s_tvalid[grant_q])  stall_d = '0;
    else                         stall_d = stall_q + CW'(1);
    err_d   = term && m_tready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign term        = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= GW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCKED;
          grant_d = pick;
          rr_d    = pick;
        end
      end
      LOCKED: begin
        if (m_tvalid && m_tready && m_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == LOCKED) begin
      if (term) begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
      end else begin
        m_tdata           = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep           = s_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        m_tlast           = s_tlast[grant_q];
        m_tvalid          = s_tvalid[grant_q];
        s_tready[grant_q] = m_tready;
      end
    end
  end

  assign busy      = (state_q == LOCKED);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_cmprs_pkt_arbiter.sv
// Scoreboard bench for cmprs_pkt_arbiter: per-port beat queues plus a packet-level round-robin model.
// Build with +define+CMPRS_ARB_TIMEOUT_EN to exercise the forced-termination path.
module tb_cmprs_pkt_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned TO = 8;
  localparam int unsigned GW = $clog2(NP);

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tready;
  logic [GW-1:0]     grant_idx;
  logic              busy, err_timeout;

  cmprs_pkt_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // term on a source descriptor: the source goes quiet long enough that a forced end is expected first;
  // term on a scoreboard entry: this is that forced beat, so err_timeout must follow
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int unsigned   gap;
    bit            term;
  } beat_t;

  beat_t       src_q [NP][$];
  beat_t       exp_q [NP][$];
  beat_t       cur   [NP];
  bit          act   [NP];
  int unsigned acc_cnt [NP];
  int          mready_mode;
  bit          done, final_done, hang;
  int          n_pass, n_chk;

  // ---------------- stimulus side ----------------
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p]          = act[p];
      s_tlast[p]           = act[p] ? cur[p].last : 1'b0;
      s_tdata[p*DW +: DW]  = act[p] ? cur[p].data : '0;
      s_tkeep[p*KW +: KW]  = act[p] ? cur[p].keep : '0;
    end
  endtask

  task automatic cycle();
    logic [NP-1:0] acc;
    beat_t h, t;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        act[p] = 1'b0;
        acc_cnt[p]++;
      end
      if (!act[p] && src_q[p].size() > 0) begin
        h = src_q[p].pop_front();
        if (h.term) begin
          t.data = '0; t.keep = '0; t.last = 1'b1; t.gap = 0; t.term = 1'b1;
          exp_q[p].push_back(t);
          h.term = 1'b0;
        end
        if (h.gap > 0) begin
          h.gap--;
          src_q[p].push_front(h);
        end else begin
          cur[p] = h;
          act[p] = 1'b1;
          exp_q[p].push_back(h);
        end
      end
    end
    drive();
    case (mready_mode)
      0:       m_tready = 1'b1;
      2:       m_tready = 1'b0;
      default: m_tready = ($urandom_range(3) != 0);
    endcase
  endtask

  function automatic beat_t mk_beat(int p, bit last, int unsigned gap);
    beat_t b;
    for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
    b.data[DW-1 -: 8] = 8'(p);
    b.keep = $urandom;
    b.last = last;
    b.gap  = gap;
    b.term = 1'b0;
    return b;
  endfunction

  task automatic add_pkt(int p, int len, int unsigned first_gap, int unsigned mid_gap_max);
    for (int i = 0; i < len; i++)
      src_q[p].push_back(mk_beat(p, i == len - 1,
                                 (i == 0) ? first_gap : $urandom_range(mid_gap_max)));
  endtask

  function automatic bit quiet();
    bit q = !busy;
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0 || act[p]) q = 1'b0;
    return q;
  endfunction

  task automatic drain(int unsigned bound);
    int unsigned n = 0;
    do begin
      cycle();
      n++;
    end while (!quiet() && n < bound);
    if (!quiet()) hang = 1'b1;
  endtask

  task automatic wait_acc(int p, int unsigned target, int unsigned bound);
    int unsigned n = 0;
    while (acc_cnt[p] < target && n < bound) begin
      cycle();
      n++;
    end
    if (acc_cnt[p] < target) hang = 1'b1;
  endtask

  // ---------------- checking side ----------------
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  logic [NP-1:0] prev_vld;
  logic [DW-1:0] prev_data;
  logic          prev_busy, prev_mv, prev_mr, prev_last, prev_eop, exp_err;
  int            model_rr, model_g, cnd;
  bit            found;
  beat_t         e;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_mdata", m_tdata, 0);
      chk("rst_err", err_timeout, 0);
      for (int p = 0; p < NP; p++) exp_q[p].delete();
      model_rr  = NP - 1;
      model_g   = 0;
      prev_busy = 1'b0;
      prev_eop  = 1'b0;
      prev_mv   = 1'b0;
      exp_err   = 1'b0;
      prev_vld  = s_tvalid;
    end else begin
      if (busy && !prev_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          cnd = (model_rr + k) % NP;
          if (!found && prev_vld[cnd]) begin
            model_g = cnd;
            found   = 1'b1;
          end
        end
        chk("grant_had_request", found, 1);
        chk("grant_rr", grant_idx, model_g);
        model_rr = model_g;
      end
      if (prev_eop) chk("bubble_after_last", busy, 0);
      if (busy) begin
        chk("grant_hold", grant_idx, model_g);
        chk("sready_others", s_tready & ~(NP'(1) << model_g), 0);
        if (s_tvalid[model_g]) chk("sready_granted", s_tready[model_g], m_tready);
        if (prev_busy && prev_mv && !prev_mr) begin
          chk("stall_valid", m_tvalid, 1);
          chk("stall_data", m_tdata, prev_data);
          chk("stall_last", m_tlast, prev_last);
        end
      end else begin
        chk("idle_sready", s_tready, 0);
        chk("idle_mvalid", m_tvalid, 0);
      end
      chk("err_timeout", err_timeout, exp_err);
      exp_err  = 1'b0;
      prev_eop = 1'b0;
      if (m_tvalid && m_tready) begin
        chk("sb_beat_expected", exp_q[model_g].size() > 0, 1);
        if (exp_q[model_g].size() > 0) begin
          e = exp_q[model_g].pop_front();
          chk("beat_data", m_tdata, e.data);
          chk("beat_keep", m_tkeep, e.keep);
          chk("beat_last", m_tlast, e.last);
          exp_err  = e.term;
          prev_eop = e.last;
        end
      end
      if (done && !final_done) begin
        final_done = 1'b1;
        chk("no_hang", hang, 0);
        for (int p = 0; p < NP; p++) chk("sb_drained", exp_q[p].size(), 0);
      end
      prev_busy = busy;
      prev_vld  = s_tvalid;
      prev_mv   = m_tvalid;
      prev_mr   = m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    beat_t b;
    n_pass = 0; n_chk = 0;
    done = 1'b0; final_done = 1'b0; hang = 1'b0;
    reset = 1'b0;
    m_tready = 1'b0;
    mready_mode = 0;
    for (int p = 0; p < NP; p++) begin
      act[p] = 1'b0;
      acc_cnt[p] = 0;
    end
    drive();
    repeat (3) cycle();
    reset = 1'b1;

    // two-beat packet on port 0 with a recognisable first beat
    b = mk_beat(0, 1'b0, 0);
    b.data = '0;
    b.data[111:96] = 16'h0008;
    src_q[0].push_back(b);
    b.data = '1; b.keep = '1; b.last = 1'b1;
    src_q[0].push_back(b);
    drain(100);

    // every port streaming single-beat packets: strict rotation
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 1, 0, 0);
    drain(200);

    // port 1 held off by m_tready for 5 cycles mid-packet
    add_pkt(1, 3, 0, 0);
    wait_acc(1, acc_cnt[1] + 1, 50);
    mready_mode = 2;
    m_tready = 1'b0;
    repeat (5) cycle();
    mready_mode = 0;
    drain(100);

`ifdef CMPRS_ARB_TIMEOUT_EN
    // port 0 goes silent mid-packet; a forced end arrives, then its remaining beats form a new packet
    src_q[0].push_back(mk_beat(0, 1'b0, 0));
    b = mk_beat(0, 1'b0, TO + 4);
    b.term = 1'b1;
    src_q[0].push_back(b);
    src_q[0].push_back(mk_beat(0, 1'b1, 0));
    add_pkt(1, 1, 3, 0);
    drain(200);
`else
    // port 0 drops tvalid for 10 cycles mid-packet while port 1 waits
    src_q[0].push_back(mk_beat(0, 1'b0, 0));
    src_q[0].push_back(mk_beat(0, 1'b0, 10));
    src_q[0].push_back(mk_beat(0, 1'b1, 0));
    add_pkt(1, 2, 0, 0);
    drain(200);
`endif

    // randomised traffic with random backpressure
    mready_mode = 1;
    for (int r = 0; r < 6; r++)
      for (int p = 0; p < NP; p++)
        if ($urandom_range(3) != 0)
          add_pkt(p, $urandom_range(4, 1), $urandom_range(5), 3);
    drain(4000);
    mready_mode = 0;

    // reset while port 0 is presenting the 2nd beat of a 4-beat packet
    add_pkt(0, 4, 0, 0);
    wait_acc(0, acc_cnt[0] + 1, 50);
    #2;
    reset = 1'b0;
    cycle();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      act[p] = 1'b0;
    end
    drive();
    cycle();
    reset = 1'b1;
    for (int p = NP - 1; p >= 0; p--) add_pkt(p, 2, 0, 0);
    drain(200);

    done = 1'b1;
    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
